logic_unit_arbiter: RTL

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

---
 rtl/logic_unit_pkg.sv | 17 +
 rtl/logic_unit_32bit.sv | 24 ++
 rtl/logic_unit_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/logic_unit_pkg.sv
// Shared constants for the two-requester logic unit: opcodes, FSM states, default width.
package logic_unit_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOR = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/logic_unit_32bit.sv
// Combinational bitwise logic unit: AND / OR / NOR / XOR selected by op.
module logic_unit_32bit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NOR:  result = ~(a | b);
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter in front of a shared logic unit: grant in IDLE, compute in EXEC,
// hold the result in RESP until the consumer takes it.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    input  logic             resp_ready,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    // Handshake: a request transfers in the cycle reqN_valid && reqN_ready (IDLE only);
    // a result transfers in the cycle resp_valid && resp_ready, after which the unit idles.

    state_t           state;
    state_t           next_state;
    logic             prio;
    logic             grant0;
    logic             grant1;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic [WIDTH-1:0] result;

    logic_unit_32bit #(.WIDTH(WIDTH)) u_logic_unit (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (result)
    );

    always_comb begin
        next_state = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            ST_IDLE: begin
                // A lone requester wins outright; prio only breaks ties.
                if (req0_valid && (!req1_valid || !prio)) begin
                    grant0     = 1'b1;
                    next_state = ST_EXEC;
                end else if (req1_valid) begin
                    grant1     = 1'b1;
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: next_state = ST_RESP;
            ST_RESP: if (resp_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            prio      <= 1'b0;
            op_q      <= 2'b00;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            resp_id   <= 1'b0;
            resp_data <= '0;
        end else begin
            state <= next_state;
            if (grant0 || grant1) begin
                op_q <= grant1 ? req1_op : req0_op;
                a_q  <= grant1 ? req1_a  : req0_a;
                b_q  <= grant1 ? req1_b  : req0_b;
                id_q <= grant1;
                prio <= grant0;
            end
            if (state == ST_EXEC) begin
                resp_data <= result;
                resp_id   <= id_q;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign resp_valid = (state == ST_RESP);
    assign busy       = (state != ST_IDLE);
    assign fsm_state  = state;

endmodule
